// File: rtl/pl_bram_ctrl_lite_v2.sv
// AXI4-Lite slave mapping a single-port BRAM into the PS address space.
// Handles range errors, byte strobes, read/write arbitration and an error counter.
module pl_bram_ctrl_lite_v2 #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int MEM_DEPTH          = 256,
  parameter int BRAM_RD_LATENCY    = 1,
  localparam int BRAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              BRAM_EN,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   BRAM_WE,
  output logic [BRAM_AW-1:0]                BRAM_ADDR,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     BRAM_WRDATA,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     BRAM_RDDATA,
  output logic [15:0]                       ERR_CNT
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int SW  = DW / 8;
  localparam int ASH = $clog2(SW);
  localparam int IW  = AW - ASH;
  localparam logic [IW:0] DEPTH_L     = (IW + 1)'(MEM_DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  LAT_LAST    = 2'(BRAM_RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_RESP = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } state_t;

  state_t          state_r;
  logic            prio_wr_r;
  logic [1:0]      lat_cnt_r;
  logic            rd_err_r;
  logic            bvalid_r;
  logic            rvalid_r;
  logic [1:0]      bresp_r;
  logic [1:0]      rresp_r;
  logic [DW-1:0]   rdata_r;
  logic [15:0]     err_cnt_r;

  logic [IW-1:0]   aw_idx_s;
  logic [IW-1:0]   ar_idx_s;
  logic            aw_ok_s;
  logic            ar_ok_s;
  logic            wr_req_s;
  logic            rd_req_s;
  logic            wr_grant_s;
  logic            rd_grant_s;
  logic            unused_s;

  function automatic logic in_range_f(input logic [IW-1:0] idx);
    in_range_f = ({1'b0, idx} < DEPTH_L);
  endfunction

  assign aw_idx_s = S_AXI_AWADDR[AW-1:ASH];
  assign ar_idx_s = S_AXI_ARADDR[AW-1:ASH];
  assign aw_ok_s  = in_range_f(aw_idx_s);
  assign ar_ok_s  = in_range_f(ar_idx_s);
  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ASH-1:0], S_AXI_ARADDR[ASH-1:0]};

  // Request qualification and arbitration; a write needs AW and W together.
  always_comb begin
    wr_req_s = 1'b0;
    rd_req_s = 1'b0;
    if ((state_r == IDLE) && !ARESET) begin
      wr_req_s = S_AXI_AWVALID && S_AXI_WVALID;
      rd_req_s = S_AXI_ARVALID;
    end else begin
      wr_req_s = 1'b0;
      rd_req_s = 1'b0;
    end
    wr_grant_s = wr_req_s && (!rd_req_s || prio_wr_r);
    rd_grant_s = rd_req_s && !wr_grant_s;
  end

  // Grant-cycle outputs are decoded from the IDLE state so the BRAM access lands in the accept cycle.
  assign S_AXI_AWREADY = wr_grant_s;
  assign S_AXI_WREADY  = wr_grant_s;
  assign S_AXI_ARREADY = rd_grant_s;
  assign BRAM_EN       = (wr_grant_s && aw_ok_s) || (rd_grant_s && ar_ok_s);
  assign BRAM_WE       = (wr_grant_s && aw_ok_s) ? S_AXI_WSTRB : {SW{1'b0}};
  assign BRAM_ADDR     = rd_grant_s ? ar_idx_s[BRAM_AW-1:0] : aw_idx_s[BRAM_AW-1:0];
  assign BRAM_WRDATA   = S_AXI_WDATA;

  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RDATA   = rdata_r;
  assign ERR_CNT       = err_cnt_r;

  // Transaction FSM, response registers, priority bit and error counter.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r   <= IDLE;
      prio_wr_r <= 1'b1;
      lat_cnt_r <= 2'd0;
      rd_err_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      rvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= {DW{1'b0}};
      err_cnt_r <= 16'd0;
    end else begin
      if (wr_req_s && rd_req_s) begin
        prio_wr_r <= !prio_wr_r;
      end
      if ((wr_grant_s && !aw_ok_s) || (rd_grant_s && !ar_ok_s)) begin
        if (err_cnt_r != 16'hFFFF) begin
          err_cnt_r <= err_cnt_r + 16'd1;
        end
      end
      case (state_r)
        IDLE: begin
          if (wr_grant_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= aw_ok_s ? RESP_OKAY : RESP_SLVERR;
            state_r  <= WR_RESP;
          end else if (rd_grant_s) begin
            rd_err_r  <= !ar_ok_s;
            lat_cnt_r <= 2'd0;
            state_r   <= RD_WAIT;
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_cnt_r == LAT_LAST) begin
            rdata_r  <= rd_err_r ? {DW{1'b0}} : BRAM_RDDATA;
            rresp_r  <= rd_err_r ? RESP_SLVERR : RESP_OKAY;
            rvalid_r <= 1'b1;
            state_r  <= RD_RESP;
          end else begin
            lat_cnt_r <= lat_cnt_r + 2'd1;
          end
        end
        RD_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pl_bram_ctrl_lite_v2.sv
// Bench for pl_bram_ctrl_lite_v2: table vectors, arbitration/reset sequences and
// randomized traffic compared against a word-array memory model.
`timescale 1ns/1ps
module tb_pl_bram_ctrl_lite_v2;

  localparam int DW = 32, AW = 12, DEPTH = 256, LAT = 2;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [AW-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]    S_AXI_AWPROT, S_AXI_ARPROT;
  logic          S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [DW-1:0] S_AXI_WDATA, S_AXI_RDATA, BRAM_WRDATA, BRAM_RDDATA;
  logic [3:0]    S_AXI_WSTRB, BRAM_WE;
  logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
  logic          S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic          S_AXI_RVALID, S_AXI_RREADY, BRAM_EN;
  logic [7:0]    BRAM_ADDR;
  logic [15:0]   ERR_CNT;

  pl_bram_ctrl_lite_v2 #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW),
    .MEM_DEPTH(DEPTH), .BRAM_RD_LATENCY(LAT)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR),
    .BRAM_WRDATA(BRAM_WRDATA), .BRAM_RDDATA(BRAM_RDDATA), .ERR_CNT(ERR_CNT)
  );

  always #5 ACLK = ~ACLK;

  // BRAM behavioural model with LAT-cycle read pipeline.
  logic [31:0] bram [0:DEPTH-1];
  logic [31:0] pipe [LAT];
  bit          mem_init_done;
  always @(posedge ACLK) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= 32'h0;
      mem_init_done <= 1'b1;
    end
    if (BRAM_EN) begin
      for (int b = 0; b < 4; b++)
        if (BRAM_WE[b]) bram[BRAM_ADDR][b*8 +: 8] <= BRAM_WRDATA[b*8 +: 8];
      pipe[0] <= bram[BRAM_ADDR];
    end
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
  end
  assign BRAM_RDDATA = pipe[LAT-1];

  int cyc = 0, en_cnt = 0, we_bad = 0;
  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (BRAM_EN) en_cnt <= en_cnt + 1;
    if (!BRAM_EN && (BRAM_WE != 4'h0)) we_bad <= we_bad + 1;
  end

  int vec = 0, errs = 0, t_hs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: flat word array, byte merge, error/enable bookkeeping.
  logic [31:0] ref_mem [0:DEPTH-1];
  int exp_err = 0, exp_en = 0;

  task automatic model_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a) / 4;
    if (idx < DEPTH) begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      exp_en++;
    end else exp_err++;
  endtask

  task automatic model_rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    int idx = int'(a) / 4;
    if (idx < DEPTH) begin d = ref_mem[idx]; r = 2'b00; exp_en++; end
    else begin d = 32'h0; r = 2'b10; exp_err++; end
  endtask

  task automatic wait_wr_hs();
    logic ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (S_AXI_AWREADY && S_AXI_WREADY) ok = 1'b1;
      else @(negedge ACLK);
    end
    chk("wr_handshake", 64'(ok), 64'd1);
    if (ok) @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    t_hs = cyc;
  endtask

  task automatic wait_rd_hs();
    logic ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (S_AXI_ARREADY) ok = 1'b1;
      else @(negedge ACLK);
    end
    chk("rd_handshake", 64'(ok), 64'd1);
    if (ok) @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    t_hs = cyc;
  endtask

  task automatic wait_b(input int hold, output logic [1:0] resp);
    logic stable = 1'b1;
    for (int i = 0; i < 50 && !S_AXI_BVALID; i++) @(negedge ACLK);
    chk("bvalid_seen", 64'(S_AXI_BVALID), 64'd1);
    chk("wr_latency", 64'(cyc - t_hs + 1), 64'd1);
    resp = S_AXI_BRESP;
    repeat (hold) begin
      @(negedge ACLK);
      if (!S_AXI_BVALID || S_AXI_BRESP !== resp) stable = 1'b0;
    end
    if (hold > 0) chk("b_hold_stable", 64'(stable), 64'd1);
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    chk("bvalid_drop", 64'(S_AXI_BVALID), 64'd0);
  endtask

  task automatic wait_r(input int hold, output logic [31:0] d, output logic [1:0] r);
    logic stable = 1'b1;
    for (int i = 0; i < 50 && !S_AXI_RVALID; i++) @(negedge ACLK);
    chk("rvalid_seen", 64'(S_AXI_RVALID), 64'd1);
    chk("rd_latency", 64'(cyc - t_hs + 1), 64'(LAT + 1));
    d = S_AXI_RDATA; r = S_AXI_RRESP;
    repeat (hold) begin
      @(negedge ACLK);
      if (!S_AXI_RVALID || S_AXI_RDATA !== d || S_AXI_RRESP !== r) stable = 1'b0;
    end
    if (hold > 0) chk("r_hold_stable", 64'(stable), 64'd1);
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    chk("rvalid_drop", 64'(S_AXI_RVALID), 64'd0);
  endtask

  task automatic axi_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold, output logic [1:0] resp);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    wait_wr_hs();
    wait_b(hold, resp);
  endtask

  task automatic axi_rd(input logic [11:0] a, input int hold, output logic [31:0] d, output logic [1:0] r);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    wait_rd_hs();
    wait_r(hold, d, r);
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          hold;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [14];
    logic [1:0]  resp, mr;
    logic [31:0] d, md;
    logic        stable;
    int          n_rand;

    tbl[0]  = '{1'b1, 12'h000, 32'h0000_0001, 4'hF, 2'b00, 32'h0000_0001, 2'b00, 0};
    tbl[1]  = '{1'b1, 12'h004, 32'h0000_0002, 4'hF, 2'b00, 32'h0000_0002, 2'b00, 1};
    tbl[2]  = '{1'b1, 12'h008, 32'h0000_0003, 4'hF, 2'b00, 32'h0000_0003, 2'b00, 0};
    tbl[3]  = '{1'b1, 12'h00C, 32'h0000_0004, 4'hF, 2'b00, 32'h0000_0004, 2'b00, 2};
    tbl[4]  = '{1'b1, 12'h010, 32'hAABB_CCDD, 4'hF, 2'b00, 32'hAABB_CCDD, 2'b00, 0};
    tbl[5]  = '{1'b1, 12'h010, 32'h1122_3344, 4'h5, 2'b00, 32'hAA22_CC44, 2'b00, 0};
    tbl[6]  = '{1'b1, 12'h3FC, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hDEAD_BEEF, 2'b00, 0};
    tbl[7]  = '{1'b1, 12'h400, 32'h1234_5678, 4'hF, 2'b10, 32'h0000_0000, 2'b10, 0};
    tbl[8]  = '{1'b1, 12'h013, 32'hCAFE_F00D, 4'h0, 2'b00, 32'hAA22_CC44, 2'b00, 0};
    tbl[9]  = '{1'b1, 12'hFFC, 32'h5555_5555, 4'hF, 2'b10, 32'h0000_0000, 2'b10, 3};
    tbl[10] = '{1'b0, 12'h000, 32'h0,         4'h0, 2'b00, 32'h0000_0001, 2'b00, 5};
    tbl[11] = '{1'b0, 12'h005, 32'h0,         4'h0, 2'b00, 32'h0000_0002, 2'b00, 0};
    tbl[12] = '{1'b0, 12'h00A, 32'h0,         4'h0, 2'b00, 32'h0000_0003, 2'b00, 0};
    tbl[13] = '{1'b0, 12'h00F, 32'h0,         4'h0, 2'b00, 32'h0000_0004, 2'b00, 5};
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

    // Reset with all requests asserted: nothing may be accepted.
    ARESET = 1'b1;
    S_AXI_AWPROT = 3'b000; S_AXI_ARPROT = 3'b000;
    S_AXI_AWADDR = 12'h0; S_AXI_ARADDR = 12'h0; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    chk("rst_ready", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'd0);
    chk("rst_bram_en", 64'({BRAM_EN, BRAM_WE}), 64'd0);
    chk("rst_valid", 64'({S_AXI_BVALID, S_AXI_RVALID}), 64'd0);
    chk("rst_resp", 64'({S_AXI_BRESP, S_AXI_RRESP}), 64'd0);
    chk("rst_rdata", 64'(S_AXI_RDATA), 64'd0);
    chk("rst_err_cnt", 64'(ERR_CNT), 64'd0);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);

    // Table vectors: optional write, then read back.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) begin
        axi_wr(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].hold, resp);
        model_wr(tbl[i].addr, tbl[i].data, tbl[i].strb);
        chk($sformatf("tbl%0d_bresp", i), 64'(resp), 64'(tbl[i].bresp));
      end
      axi_rd(tbl[i].addr, tbl[i].hold, d, resp);
      model_rd(tbl[i].addr, md, mr);
      chk($sformatf("tbl%0d_rdata", i), 64'(d), 64'(tbl[i].rdata));
      chk($sformatf("tbl%0d_rresp", i), 64'(resp), 64'(tbl[i].rresp));
    end
    chk("tbl_err_cnt", 64'(ERR_CNT), 64'd4);
    chk("tbl_en_count", 64'(en_cnt), 64'(exp_en));

    // AW waits for W: no READY until both valid, then both together.
    S_AXI_AWADDR = 12'h030; S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1;
    repeat (3) begin
      #1;
      chk("aw_without_w", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'd0);
      @(negedge ACLK);
    end
    S_AXI_WVALID = 1'b1;
    #1;
    chk("aw_w_together", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'd3);
    wait_wr_hs();
    wait_b(0, resp);
    model_wr(12'h030, 32'h0BAD_F00D, 4'hF);
    chk("aw_late_w_bresp", 64'(resp), 64'd0);

    // Simultaneous write and read: write first, then read first.
    S_AXI_AWADDR = 12'h020; S_AXI_WDATA = 32'h1111_AAAA; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 12'h020;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    #1;
    chk("arb1_write_first", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'd6);
    wait_wr_hs();
    model_wr(12'h020, 32'h1111_AAAA, 4'hF);
    wait_b(0, resp);
    wait_rd_hs();
    wait_r(0, d, resp);
    model_rd(12'h020, md, mr);
    chk("arb1_read_data", 64'(d), 64'(md));
    S_AXI_WDATA = 32'h2222_BBBB;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    #1;
    chk("arb2_read_first", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'd1);
    wait_rd_hs();
    model_rd(12'h020, md, mr);
    wait_r(0, d, resp);
    chk("arb2_read_old_data", 64'(d), 64'(md));
    wait_wr_hs();
    model_wr(12'h020, 32'h2222_BBBB, 4'hF);
    wait_b(0, resp);
    axi_rd(12'h020, 0, d, resp);
    model_rd(12'h020, md, mr);
    chk("arb2_read_new_data", 64'(d), 64'(md));

    // Reset during RD_WAIT abandons the read; the next read is correct.
    S_AXI_ARADDR = 12'h000; S_AXI_ARVALID = 1'b1;
    wait_rd_hs();
    exp_en++;
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    exp_err = 0;
    chk("rst_mid_err_cnt", 64'(ERR_CNT), 64'd0);
    stable = 1'b1;
    repeat (5) begin
      if (S_AXI_RVALID || S_AXI_BVALID) stable = 1'b0;
      @(negedge ACLK);
    end
    chk("rst_mid_no_resp", 64'(stable), 64'd1);
    axi_rd(12'h000, 5, d, resp);
    model_rd(12'h000, md, mr);
    chk("rst_mid_next_read", 64'(d), 64'(md));

    // Randomized traffic against the reference model.
    n_rand = 150;
    for (int i = 0; i < n_rand; i++) begin
      logic [11:0] a  = 12'($urandom_range(0, 12'h47F));
      logic [31:0] wd = $urandom;
      logic [3:0]  ws = 4'($urandom_range(0, 15));
      int          h  = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        axi_wr(a, wd, ws, h, resp);
        model_wr(a, wd, ws);
        chk("rand_bresp", 64'(resp), 64'((int'(a) / 4 < DEPTH) ? 2'b00 : 2'b10));
      end else begin
        axi_rd(a, h, d, resp);
        model_rd(a, md, mr);
        chk("rand_rdata", 64'(d), 64'(md));
        chk("rand_rresp", 64'(resp), 64'(mr));
      end
    end
    chk("final_err_cnt", 64'(ERR_CNT), 64'(exp_err));
    chk("final_en_count", 64'(en_cnt), 64'(exp_en));
    chk("we_without_en", 64'(we_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
